pc_fetch_unit: RTL and testbench

- Instruction-fetch front end upstream of the PC/branch-target adder: owns the architectural fetch PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Consumes the adder's branch-target sum and trap redirects.
- Selects the next PC and flags misaligned targets.
- Signals a flush to IF/ID on every redirect.

---
 rtl/pc_fetch_unit_pkg.sv | 23 ++
 rtl/pc_fetch_unit_adder.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package pc_fetch_unit_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // Byte distance between consecutive sequential fetches
    localparam int unsigned INSTR_STEP = 4;

    // PC loaded while reset is held
    localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0000_0000_8000_0000;

    // Low address bits that must be zero for a legal fetch target.
    // With compressed instructions only bit 0 matters; otherwise bits 1:0.
    function automatic logic [1:0] align_mask(input bit c_ext);
        return c_ext ? 2'b01 : 2'b11;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// Generic two-operand adder used for the sequential PC increment.
// PIPELINED=0 gives a purely combinational sum; PIPELINED=1 registers it.
module pc_fetch_unit_adder #(
    parameter int WIDTH     = 64,
    parameter bit PIPELINED = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] q_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o,
    output logic             overflow_o
);

    logic [WIDTH:0]   full_sum;
    logic             ovf;

    assign full_sum = {1'b0, p_i} + {1'b0, q_i};
    assign ovf      = (p_i[WIDTH-1] == q_i[WIDTH-1]) && (full_sum[WIDTH-1] != p_i[WIDTH-1]);

    if (PIPELINED) begin : g_pipe
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             ovf_q;

        // Register the result for timing-critical contexts
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                sum_q   <= full_sum[WIDTH-1:0];
                carry_q <= full_sum[WIDTH];
                ovf_q   <= ovf;
            end
        end

        assign sum_o       = sum_q;
        assign carry_out_o = carry_q;
        assign overflow_o  = ovf_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk_i, rst_n_i};

        assign sum_o       = full_sum[WIDTH-1:0];
        assign carry_out_o = full_sum[WIDTH];
        assign overflow_o  = ovf;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues requests over a
// valid/ready handshake, applies branch/trap redirects and traps misaligned
// branch targets into a FAULT state until a trap redirect arrives.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter bit              C_EXT        = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            trap_redirect_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic [31:0]     fetch_count_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic            flush_q, flush_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] mis_addr_q, mis_addr_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [XLEN-1:0] pc_plus_step;
    logic            adder_unused_carry;
    logic            adder_unused_ovf;
    logic            req_valid;
    logic            fire;
    logic            target_misaligned;

    pc_fetch_unit_adder #(
        .WIDTH     (XLEN),
        .PIPELINED (1'b0)
    ) u_pc_adder (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .p_i         (pc_q),
        .q_i         (XLEN'(INSTR_STEP)),
        .sum_o       (pc_plus_step),
        .carry_out_o (adder_unused_carry),
        .overflow_o  (adder_unused_ovf)
    );

    // A pending request keeps valid high through stall until it is accepted
    assign req_valid         = (state_q == ST_FETCH) && (pend_q || !stall_i);
    assign fire              = req_valid && imem_req_ready_i;
    assign target_misaligned = |(branch_target_i[1:0] & align_mask(C_EXT));

    // Next-state, next-PC selection and handshake bookkeeping
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        flush_d    = 1'b0;
        mis_d      = mis_q;
        mis_addr_d = mis_addr_q;
        cnt_d      = cnt_q + {31'd0, fire};

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (trap_redirect_i) begin
                    pc_d    = trap_vector_i;
                    flush_d = 1'b1;
                    mis_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (branch_taken_i) begin
                    flush_d = 1'b1;
                    pend_d  = 1'b0;
                    if (target_misaligned) begin
                        mis_d      = 1'b1;
                        mis_addr_d = branch_target_i;
                        state_d    = ST_FAULT;
                    end else begin
                        pc_d = branch_target_i;
                    end
                end else if (fire) begin
                    pc_d   = pc_plus_step;
                    pend_d = 1'b0;
                end else if (req_valid) begin
                    pend_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (trap_redirect_i) begin
                    pc_d    = trap_vector_i;
                    flush_d = 1'b1;
                    mis_d   = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; async reset abandons any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            flush_q    <= flush_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_addr_o      = pc_q;
    assign flush_o          = flush_q;
    assign misalign_o       = mis_q;
    assign misalign_addr_o  = mis_addr_q;
    assign fetch_count_o    = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (C_EXT=0 instance).
module tb_pc_fetch_unit;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst_n;
    logic            stall_i;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            trap_redirect_i;
    logic [XLEN-1:0] trap_vector_i;
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_addr_o;
    logic            flush_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;
    logic [31:0]     fetch_count_o;

    int total;
    int bad;

    pc_fetch_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (64'h0000_0000_8000_0000),
        .C_EXT        (1'b0)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .trap_redirect_i  (trap_redirect_i),
        .trap_vector_i    (trap_vector_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .flush_o          (flush_o),
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o),
        .fetch_count_o    (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic vld, input logic [63:0] addr,
                             input logic [31:0] cnt, input logic fl);
        chk({tag, "_valid"}, 64'(imem_req_valid_o), 64'(vld));
        chk({tag, "_addr"},  imem_addr_o, addr);
        chk({tag, "_count"}, 64'(fetch_count_o), 64'(cnt));
        chk({tag, "_flush"}, 64'(flush_o), 64'(fl));
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst_n           = 1'b0;
        stall_i         = 1'b0;
        branch_taken_i  = 1'b0;
        branch_target_i = '0;
        trap_redirect_i = 1'b0;
        trap_vector_i   = '0;
        imem_req_ready_i = 1'b1;

        // Reset state
        step();
        step();
        chk_fetch("rst", 1'b0, 64'h8000_0000, 32'd0, 1'b0);
        chk("rst_mis",      64'(misalign_o), 64'd0);
        chk("rst_mis_addr", misalign_addr_o, 64'd0);

        // Release reset; IDLE for one edge, then streaming fetches
        rst_n = 1'b1;
        chk("idle_valid", 64'(imem_req_valid_o), 64'd0);
        step();
        chk_fetch("seq0", 1'b1, 64'h8000_0000, 32'd0, 1'b0);
        step();
        chk_fetch("seq1", 1'b1, 64'h8000_0004, 32'd1, 1'b0);
        step();
        chk_fetch("seq2", 1'b1, 64'h8000_0008, 32'd2, 1'b0);
        step();
        chk_fetch("seq3", 1'b1, 64'h8000_000C, 32'd3, 1'b0);
        step();
        chk_fetch("seq4", 1'b1, 64'h8000_0010, 32'd4, 1'b0);

        // Backpressure from memory while stall toggles: request held
        imem_req_ready_i = 1'b0;
        step();
        chk_fetch("hold0", 1'b1, 64'h8000_0010, 32'd4, 1'b0);
        stall_i = 1'b1;
        #1;
        chk("hold_stall_valid", 64'(imem_req_valid_o), 64'd1);
        step();
        chk_fetch("hold1", 1'b1, 64'h8000_0010, 32'd4, 1'b0);
        stall_i = 1'b0;
        step();
        chk_fetch("hold2", 1'b1, 64'h8000_0010, 32'd4, 1'b0);
        stall_i = 1'b1;
        imem_req_ready_i = 1'b1;
        step();
        chk_fetch("hold_fire", 1'b0, 64'h8000_0014, 32'd5, 1'b0);
        stall_i = 1'b0;
        #1;
        chk("unstall_valid", 64'(imem_req_valid_o), 64'd1);

        // Taken branch coincident with fire
        branch_taken_i  = 1'b1;
        branch_target_i = 64'h8000_1000;
        step();
        branch_taken_i = 1'b0;
        chk_fetch("br", 1'b1, 64'h8000_1000, 32'd6, 1'b1);
        step();
        chk_fetch("br_next", 1'b1, 64'h8000_1004, 32'd7, 1'b0);

        // Misaligned target (bit 1 set, 4-byte alignment required)
        branch_taken_i  = 1'b1;
        branch_target_i = 64'h8000_2002;
        step();
        chk_fetch("mis", 1'b0, 64'h8000_1004, 32'd8, 1'b1);
        chk("mis_flag", 64'(misalign_o), 64'd1);
        chk("mis_addr", misalign_addr_o, 64'h8000_2002);
        branch_target_i = 64'h8000_3000;
        step();
        chk_fetch("fault_hold", 1'b0, 64'h8000_1004, 32'd8, 1'b0);
        chk("fault_flag", 64'(misalign_o), 64'd1);
        branch_taken_i  = 1'b0;
        trap_redirect_i = 1'b1;
        trap_vector_i   = 64'h8000_0100;
        step();
        trap_redirect_i = 1'b0;
        chk_fetch("trap", 1'b1, 64'h8000_0100, 32'd8, 1'b1);
        chk("trap_mis", 64'(misalign_o), 64'd0);

        // Branch and trap together: trap wins
        branch_taken_i  = 1'b1;
        branch_target_i = 64'h9000;
        trap_redirect_i = 1'b1;
        trap_vector_i   = 64'hA000;
        step();
        branch_taken_i  = 1'b0;
        trap_redirect_i = 1'b0;
        chk_fetch("prio", 1'b1, 64'hA000, 32'd9, 1'b1);

        // PC wrap across 2^64
        trap_redirect_i = 1'b1;
        trap_vector_i   = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        trap_redirect_i = 1'b0;
        chk_fetch("top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'd10, 1'b1);
        step();
        chk_fetch("pc_wrap", 1'b1, 64'h0, 32'd11, 1'b0);

        // Counter wrap from a preloaded value
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        #1;
        chk("cnt_preset", 64'(fetch_count_o), 64'hFFFF_FFFE);
        step();
        chk_fetch("cnt_max", 1'b1, 64'h4, 32'hFFFF_FFFF, 1'b0);
        step();
        chk_fetch("cnt_wrap", 1'b1, 64'h8, 32'd0, 1'b0);

        // Async reset during an outstanding request
        imem_req_ready_i = 1'b0;
        step();
        chk_fetch("pre_rst", 1'b1, 64'h8, 32'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_fetch("async_rst", 1'b0, 64'h8000_0000, 32'd0, 1'b0);
        step();
        chk("rst_hold_valid", 64'(imem_req_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
